// File: rtl/fifo_push_arbiter.sv
// Round-robin push-side arbiter for the shared fifo with bounded bursts per grant.
// Optional per-requester beat counters are enabled with `define FIFO_ARB_STATS_EN.

`ifdef FIFO_ARB_STATS_EN
module fifo_arb_stat_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!reset)                          cnt <= '0;
    else if (inc && (cnt != {W{1'b1}})) cnt <= cnt + 1'b1;
  end
endmodule
`endif

module fifo_push_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int DW     = 8,
  parameter  int BURST  = 4,
  parameter  int STAT_W = 8,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [DW-1:0]        fifo_data_in,
  output logic [IW-1:0]        owner,
  output logic                 busy,
  input  logic [IW-1:0]        stat_sel,
  output logic [STAT_W-1:0]    stat_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state, nxt_state;
  logic [IW-1:0]             rr_ptr, nxt_rr, owner_q, nxt_owner, winner, sel;
  logic [3:0]                beat_cnt, nxt_beat;
  logic                      found;
  logic [NREQ-1:0][DW-1:0]   data_v;

  assign data_v = req_data;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(NREQ-1)) ? '0 : x + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, modulo NREQ.
  always_comb begin
    int sum;
    winner = '0;
    found  = 1'b0;
    sum    = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      if (!found && req_valid[IW'(sum)]) begin
        winner = IW'(sum);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_rr    = rr_ptr;
    nxt_owner = owner_q;
    nxt_beat  = beat_cnt;
    sel       = owner_q;
    req_ready = '0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (!fifo_full && found) begin
            req_ready[winner] = 1'b1;
            sel               = winner;
            nxt_owner         = winner;
            if (BURST == 1) begin
              nxt_rr = wrap_inc(winner);
            end else begin
              nxt_beat  = 4'd1;
              nxt_state = HOLD;
            end
          end
        end
        HOLD: begin
          // A finished burst hands over through one no-transfer cycle,
          // the same gap an early release produces.
          if (beat_cnt == 4'(BURST) || !req_valid[owner_q]) begin
            nxt_rr    = wrap_inc(owner_q);
            nxt_beat  = 4'd0;
            nxt_state = IDLE;
          end else if (!fifo_full) begin
            req_ready[owner_q] = 1'b1;
            nxt_beat           = beat_cnt + 4'd1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner_q  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= nxt_state;
      rr_ptr   <= nxt_rr;
      owner_q  <= nxt_owner;
      beat_cnt <= nxt_beat;
    end
  end

  assign fifo_push    = |(req_valid & req_ready);
  assign fifo_data_in = data_v[sel];
  assign owner        = owner_q;
  assign busy         = (state == HOLD);

`ifdef FIFO_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] cnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    fifo_arb_stat_ctr #(.W(STAT_W)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (req_valid[i] & req_ready[i]),
      .cnt   (cnt[i])
    );
  end

  assign stat_cnt = (int'(stat_sel) < NREQ) ? cnt[stat_sel] : '0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized self-checking bench for fifo_push_arbiter against a queue-based producer/arbiter model.
module tb_fifo_push_arbiter;
  localparam int NREQ = 4, DW = 8, BURST = 4, STAT_W = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                fifo_full = 1'b0;
  logic                fifo_push;
  logic [DW-1:0]       fifo_data_in;
  logic [1:0]          owner;
  logic                busy;
  logic [1:0]          stat_sel = '0;
  logic [STAT_W-1:0]   stat_cnt;

  fifo_push_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_data_in(fifo_data_in), .owner(owner), .busy(busy),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  // Producers: each requester drains its own queue of pending beats.
  logic [DW-1:0] q [NREQ][$];
  int checks = 0, errors = 0;

  // Reference model of the arbitration rules.
  bit m_busy;
  int m_ptr, m_owner, m_beat;
  int m_cnt [NREQ];
  logic [DW-1:0] plog[$];
  bit pbits[$];
  int glog[$];

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_owner = 0; m_beat = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) q[i].delete();
    plog.delete(); pbits.delete(); glog.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (q[i].size() > 0);
      req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic cycle();
    logic [NREQ-1:0] v, er;
    logic [STAT_W-1:0] es;
    int w;
    drive();
    #1;
    v = req_valid; er = '0; w = -1;
    if (reset && !fifo_full) begin
      if (!m_busy) w = pick(v);
      else if (m_beat < BURST && v[m_owner]) w = m_owner;
    end
    if (w >= 0) er[w] = 1'b1;
    checks++;
    if (req_ready !== er) begin errors++; $display("FAIL ready got %b exp %b t=%0t", req_ready, er, $time); end
    checks++;
    if (fifo_push !== (w >= 0)) begin errors++; $display("FAIL push got %b exp %b t=%0t", fifo_push, (w >= 0), $time); end
    if (w >= 0) begin
      checks++;
      if (fifo_data_in !== q[w][0]) begin errors++; $display("FAIL data got %h exp %h t=%0t", fifo_data_in, q[w][0], $time); end
    end
    checks++;
    if (busy !== m_busy) begin errors++; $display("FAIL busy got %b exp %b t=%0t", busy, m_busy, $time); end
    checks++;
    if (owner !== 2'(m_owner)) begin errors++; $display("FAIL owner got %0d exp %0d t=%0t", owner, m_owner, $time); end
`ifdef FIFO_ARB_STATS_EN
    es = STAT_W'(m_cnt[stat_sel]);
`else
    es = '0;
`endif
    checks++;
    if (stat_cnt !== es) begin errors++; $display("FAIL stat got %h exp %h t=%0t", stat_cnt, es, $time); end
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      pbits.push_back(w >= 0);
      if (w >= 0) begin
        plog.push_back(q[w].pop_front());
        if (m_cnt[w] < (1 << STAT_W) - 1) m_cnt[w]++;
      end
      if (!m_busy) begin
        if (w >= 0) begin
          glog.push_back(w);
          m_owner = w;
          if (BURST == 1) m_ptr = (w + 1) % NREQ;
          else begin m_busy = 1; m_beat = 1; end
        end
      end else if (m_beat == BURST || !v[m_owner]) begin
        m_ptr = (m_owner + 1) % NREQ; m_beat = 0; m_busy = 0;
      end else if (w >= 0) m_beat++;
    end
    #1;
  endtask

  task automatic run_until_empty(input int bound);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < bound) begin
      cycle(); n++;
    end
    if (n >= bound) begin errors++; $display("FAIL drain timeout after %0d cycles", bound); end
  endtask

  task automatic do_reset();
    clear_all();
    fifo_full = 0;
    reset = 0;
    drive();
    @(posedge clk); #1;
    model_reset();
    cycle(); cycle();
    reset = 1;
    clear_all();
  endtask

  task automatic test_reset();
    clear_all();
    for (int i = 0; i < NREQ; i++) q[i].push_back(8'(8'hA0 + i));
    reset = 0;
    drive();
    @(posedge clk); #1;
    model_reset();
    repeat (3) cycle();
    reset = 1;
    clear_all();
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    bit exp_p [7] = '{1, 1, 1, 1, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 6; i++) q[1].push_back(exp_d[i]);
    run_until_empty(40);
    checks++;
    if (plog.size() != 6) begin errors++; $display("FAIL single_count got %0d exp 6", plog.size()); end
    for (int i = 0; i < 6 && i < plog.size(); i++) begin
      checks++;
      if (plog[i] !== exp_d[i]) begin errors++; $display("FAIL single_order[%0d] got %h exp %h", i, plog[i], exp_d[i]); end
    end
    for (int i = 0; i < 7 && i < pbits.size(); i++) begin
      checks++;
      if (pbits[i] != exp_p[i]) begin errors++; $display("FAIL single_gap[%0d] got %0d exp %0d", i, pbits[i], exp_p[i]); end
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int b = 0; b < 8; b++) q[i].push_back(8'(i * 16 + b));
    repeat (22) cycle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= glog.size() || glog[i] != exp_g[i]) begin
        errors++; $display("FAIL rr_owner[%0d] got %0d exp %0d", i, (i < glog.size()) ? glog[i] : -1, exp_g[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (pbits[i] != ((i % 5) != 4)) begin errors++; $display("FAIL rr_gap[%0d] got %0d exp %0d", i, pbits[i], (i % 5) != 4); end
    end
    run_until_empty(100);
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int b = 0; b < 4; b++) q[0].push_back(8'(8'hC0 + b));
    cycle(); cycle();
    fifo_full = 1;
    repeat (3) begin
      cycle();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", busy); end
    end
    fifo_full = 0;
    run_until_empty(20);
    checks++;
    if (plog.size() != 4) begin errors++; $display("FAIL stall_count got %0d exp 4", plog.size()); end
    for (int i = 0; i < 4 && i < plog.size(); i++) begin
      checks++;
      if (plog[i] !== 8'(8'hC0 + i)) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", i, plog[i], 8'(8'hC0 + i)); end
    end
  endtask

  task automatic test_early_release();
    int exp_g [3] = '{3, 0, 2};
    do_reset();
    q[3].push_back(8'h31);
    cycle();
    q[0].push_back(8'h01);
    q[2].push_back(8'h21);
    run_until_empty(20);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= glog.size() || glog[i] != exp_g[i]) begin
        errors++; $display("FAIL wrap_owner[%0d] got %0d exp %0d", i, (i < glog.size()) ? glog[i] : -1, exp_g[i]);
      end
    end
  endtask

  task automatic test_stats();
    logic [STAT_W-1:0] e2;
    do_reset();
    for (int b = 0; b < 300; b++) q[2].push_back(8'(b));
    run_until_empty(1000);
    repeat (2) cycle();
`ifdef FIFO_ARB_STATS_EN
    e2 = 8'hFF;
`else
    e2 = 8'h00;
`endif
    for (int s = 0; s < NREQ; s++) begin
      stat_sel = 2'(s);
      #1;
      checks++;
      if (stat_cnt !== ((s == 2) ? e2 : 8'h00)) begin
        errors++; $display("FAIL stat_sel%0d got %h exp %h", s, stat_cnt, (s == 2) ? e2 : 8'h00);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) q[$urandom_range(0, NREQ-1)].push_back(8'($urandom));
      fifo_full = ($urandom_range(0, 9) < 3);
      stat_sel  = 2'($urandom_range(0, NREQ-1));
      cycle();
    end
    fifo_full = 0;
    run_until_empty(2000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
